// File: rtl/fetch_unit.sv
// Fetch front end: PC, one-outstanding imem requests, valid/ready to decode.
// Define FETCH_PERF_EN to add the perf_fetched/perf_squashed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;

  logic [31:0] redir_pc;
  logic        req_fire;
  logic        rsp_fire;

  assign redir_pc = redirect_pc & ~32'h3;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = (state == S_WAIT) && imem_rsp_valid;

  // Fetch FSM; a redirect overrides every other event in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      req_pc         <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= 32'h0;
    end else if (redirect_valid) begin
      pc          <= redir_pc;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      unique case (state)
        S_IDLE, S_HOLD: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
          imem_addr      <= redir_pc;
        end
        S_REQ: begin
          if (req_fire) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
            drop           <= 1'b1;
          end else begin
            imem_addr <= redir_pc;
          end
        end
        S_WAIT: begin
          if (rsp_fire) begin
            state          <= S_REQ;
            drop           <= 1'b0;
            imem_req_valid <= 1'b1;
            imem_addr      <= redir_pc;
          end else begin
            drop <= 1'b1;
          end
        end
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
          imem_addr      <= pc;
        end
        S_REQ: begin
          if (req_fire) begin
            state          <= S_WAIT;
            req_pc         <= pc;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rsp_fire) begin
            if (drop) begin
              state          <= S_REQ;
              drop           <= 1'b0;
              imem_req_valid <= 1'b1;
              imem_addr      <= pc;
            end else begin
              state       <= S_HOLD;
              instr       <= imem_rsp_data;
              instr_pc    <= req_pc;
              instr_valid <= 1'b1;
              pc          <= req_pc + 32'd4;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            state          <= S_REQ;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            imem_req_valid <= 1'b1;
            imem_addr      <= pc;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetched_ev;
  logic squash_ev;

  assign fetched_ev = instr_valid && instr_ready && !redirect_valid;
  assign squash_ev  = rsp_fire && (drop || redirect_valid);

  // Count delivered instructions and discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= 32'h0;
      perf_squashed <= 32'h0;
    end else begin
      if (fetched_ev) perf_fetched <= perf_fetched + 32'd1;
      if (squash_ev) perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule
